// File: rtl/tdc_pkg.sv
// tdc_pkg: shared types and constants for the TDC coarse measurement sequencer.
//   tdc_state_t     - sequencer state encoding (IDLE, ARMED, COUNT, DONE)
//   TDC_CNT_WIDTH   - default coarse counter / result width
//   TDC_TIMEOUT_OFF - cfg_timeout value that disables the timeout
package tdc_pkg;

  localparam int unsigned TDC_CNT_WIDTH   = 16;
  localparam int unsigned TDC_TIMEOUT_OFF = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } tdc_state_t;

endpackage

// File: rtl/tdc_edge_det.sv
// tdc_edge_det: registered rising-edge detector for a clk-synchronous level.
// A level held high for many cycles yields a single one-cycle pulse, one
// cycle after the rising edge is sampled.
// Ports:
//   clk   - system clock, rising edge
//   rst   - synchronous active-high reset (previous value cleared to 0)
//   d     - input level
//   pulse - one-cycle pulse for each 0->1 transition of d
module tdc_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic prev_q;
  logic prev_d;
  logic pulse_q;
  logic pulse_d;

  // Next-state: remember the current level, flag a 0->1 transition
  always_comb begin
    prev_d  = d;
    pulse_d = d & ~prev_q;
  end

  // Detector registers
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/tdc_meas_ctrl.sv
// tdc_meas_ctrl: TDC coarse measurement sequencer.
// Arms on request, waits for a start event, counts clk cycles until a stop
// event or a programmable timeout, then offers the coarse result on a
// valid/ready interface.
// Optional build macro: TDC_EDGE_DETECT_EN - start_in/stop_in pass through
// registered rising-edge detectors (both delayed by one cycle, so the
// measured interval is unchanged).
// Ports:
//   clk, rst          - system clock; synchronous active-high reset
//   arm               - request a measurement (honoured in IDLE only)
//   abort             - cancel everything, back to IDLE next cycle
//   start_in, stop_in - start/stop events, synchronous to clk
//   cfg_timeout       - timeout in cycles (0 = no timeout), sampled at start
//   busy              - high in ARMED, COUNT and DONE
//   result_data       - coarse cycle count
//   result_timeout    - measurement ended by timeout
//   result_overflow   - counter saturated
//   result_valid      - result available
//   result_ready      - downstream accepts the result
module tdc_meas_ctrl
  import tdc_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = TDC_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm,
  input  logic                 abort,
  input  logic                 start_in,
  input  logic                 stop_in,
  input  logic [CNT_WIDTH-1:0] cfg_timeout,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] result_data,
  output logic                 result_timeout,
  output logic                 result_overflow,
  output logic                 result_valid,
  input  logic                 result_ready
);

  localparam logic [CNT_WIDTH-1:0] TMO_OFF = CNT_WIDTH'(TDC_TIMEOUT_OFF);

  logic start_s;
  logic stop_s;

`ifdef TDC_EDGE_DETECT_EN
  tdc_edge_det u_start_det (
    .clk   (clk),
    .rst   (rst),
    .d     (start_in),
    .pulse (start_s)
  );

  tdc_edge_det u_stop_det (
    .clk   (clk),
    .rst   (rst),
    .d     (stop_in),
    .pulse (stop_s)
  );
`else
  assign start_s = start_in;
  assign stop_s  = stop_in;
`endif

  tdc_state_t           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] tmo_q, tmo_d;
  logic                 ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0] res_data_q, res_data_d;
  logic                 res_timeout_q, res_timeout_d;
  logic                 res_overflow_q, res_overflow_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;

  // One bit wider than the counter so the timeout compare cannot alias on wrap
  logic [CNT_WIDTH:0]   cnt_inc_s;
  logic                 cnt_sat_s;
  logic                 tmo_hit_s;

  // Saturating increment: all-ones stays all-ones
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    logic [CNT_WIDTH-1:0] r;
    if (v == {CNT_WIDTH{1'b1}}) begin
      r = v;
    end else begin
      r = v + CNT_WIDTH'(1);
    end
    return r;
  endfunction

  // Counter status: saturation and timeout hit for the current cycle
  always_comb begin
    cnt_inc_s = {1'b0, cnt_q} + (CNT_WIDTH + 1)'(1);
    cnt_sat_s = (cnt_q == {CNT_WIDTH{1'b1}});
    tmo_hit_s = (tmo_q != TMO_OFF) && (cnt_inc_s == {1'b0, tmo_q});
  end

  // Next-state and result computation
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    tmo_d          = tmo_q;
    ovf_d          = ovf_q;
    res_data_d     = res_data_q;
    res_timeout_d  = res_timeout_q;
    res_overflow_d = res_overflow_q;

    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d = ARMED;
        end else begin
          state_d = IDLE;
        end
      end

      ARMED: begin
        if (start_s && stop_s) begin
          // Coincident start/stop: zero-length measurement
          state_d        = DONE;
          res_data_d     = {CNT_WIDTH{1'b0}};
          res_timeout_d  = 1'b0;
          res_overflow_d = 1'b0;
        end else if (start_s) begin
          state_d = COUNT;
          cnt_d   = {CNT_WIDTH{1'b0}};
          ovf_d   = 1'b0;
          tmo_d   = cfg_timeout;
        end else begin
          state_d = ARMED;
        end
      end

      COUNT: begin
        if (stop_s) begin
          // Stop wins over a timeout falling in the same cycle
          state_d        = DONE;
          res_data_d     = sat_inc(cnt_q);
          res_timeout_d  = 1'b0;
          res_overflow_d = ovf_q | cnt_sat_s;
        end else if (tmo_hit_s) begin
          state_d        = DONE;
          res_data_d     = tmo_q;
          res_timeout_d  = 1'b1;
          res_overflow_d = ovf_q;
        end else if (cnt_sat_s) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_inc_s[CNT_WIDTH-1:0];
        end
      end

      DONE: begin
        if (result_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort) begin
      state_d = IDLE;
    end else begin
      state_d = state_d;
    end

    busy_d  = (state_d != IDLE);
    valid_d = (state_d == DONE);
  end

  // Sequencer, counter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= {CNT_WIDTH{1'b0}};
      tmo_q          <= {CNT_WIDTH{1'b0}};
      ovf_q          <= 1'b0;
      res_data_q     <= {CNT_WIDTH{1'b0}};
      res_timeout_q  <= 1'b0;
      res_overflow_q <= 1'b0;
      busy_q         <= 1'b0;
      valid_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      tmo_q          <= tmo_d;
      ovf_q          <= ovf_d;
      res_data_q     <= res_data_d;
      res_timeout_q  <= res_timeout_d;
      res_overflow_q <= res_overflow_d;
      busy_q         <= busy_d;
      valid_q        <= valid_d;
    end
  end

  assign busy            = busy_q;
  assign result_valid    = valid_q;
  assign result_data     = res_data_q;
  assign result_timeout  = res_timeout_q;
  assign result_overflow = res_overflow_q;

endmodule

// File: doc/tdc_meas_ctrl.md
# tdc_meas_ctrl

Measurement sequencer for the TDC coarse counter. It arms on request, waits for a start event and counts `clk` cycles until a stop event or a programmable timeout. It then presents the coarse result on a valid/ready output for the readout logic. It sits between the start/stop hit conditioning and the readout FIFO, and in the bench it is driven by the free-running clock generator.

## Interface
Parameters:
- `CNT_WIDTH`, 16: coarse counter and result width.

Ports:
- `clk`, in, 1: single system clock. All logic on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `arm`, in, 1: request a new measurement. Honoured only in IDLE.
- `abort`, in, 1: cancel any measurement and return to IDLE.
- `start_in`, in, 1: start event, synchronous to `clk`.
- `stop_in`, in, 1: stop event, synchronous to `clk`.
- `cfg_timeout`, in, CNT_WIDTH: timeout in cycles. 0 disables the timeout.
- `busy`, out, 1: high in ARMED, COUNT and DONE.
- `result_data`, out, CNT_WIDTH: coarse cycle count.
- `result_timeout`, out, 1: the result ended by timeout.
- `result_overflow`, out, 1: the counter saturated.
- `result_valid`, out, 1: a result is available.
- `result_ready`, in, 1: downstream accepts the result.

## Operation
- The FSM has four states: IDLE, ARMED, COUNT, DONE.
- IDLE:
  - `arm`=1 → ARMED.
  - `start_in` and `stop_in` are ignored.
- ARMED:
  - `start_in`=1 → COUNT with `cnt`=0.
  - `start_in` and `stop_in` both 1 in the same cycle → DONE with result 0.
  - `stop_in` alone is ignored.
- COUNT:
  - `cnt` increments by 1 each cycle.
  - `stop_in`=1 → DONE, `result_data` = `cnt`+1.
  - Timeout: `cfg_timeout`≠0, `cnt`+1 equals `cfg_timeout`, and no stop → DONE with `result_timeout`=1 and `result_data`=`cfg_timeout`.
  - Stop and timeout in the same cycle: stop wins and `result_timeout`=0.
  - Repeated `start_in` is ignored.
- Saturation:
  - `cnt` stops at all-ones and sets the overflow flag.
  - The block stays in COUNT until stop, timeout or abort.
  - The flag is reported as `result_overflow`.
- DONE:
  - `result_valid`=1 and the outputs are held stable.
  - `result_valid && result_ready` → IDLE.
  - `arm` is ignored until the transfer completes.
- `abort` overrides everything:
  - From any state → IDLE next cycle.
  - Any pending result is discarded and `result_valid` drops.
- `cfg_timeout` is sampled on the ARMED→COUNT transition. Later changes do not affect the running measurement.

## Timing
- Reset values:
  - state IDLE, `cnt`=0, `busy`=0, `result_valid`=0.
  - `result_data`=0, `result_timeout`=0, `result_overflow`=0.
- `arm` sampled at edge n → `busy`=1 after edge n.
- Start at edge s and stop at edge s+k (k≥1) → `result_data`=k. `result_valid` rises after edge s+k.
- `result_valid` does not depend combinationally on `result_ready`. `result_ready` may be held high continuously.
- Back-to-back measurements:
  - Handshake at edge h → IDLE after h.
  - `arm` at h+1 → ARMED after h+1.
  - Minimum inter-measurement gap is 2 cycles.
- Reset mid-measurement: all outputs go to their reset values after the next edge, and the result is lost.

## Configuration
- `TDC_EDGE_DETECT_EN` defined:
  - `start_in` and `stop_in` pass through rising-edge detectors, each a registered previous value.
  - Level-held inputs produce one event.
  - Start and stop are both delayed 1 cycle, so the measured k is unchanged.
  - Each detector's registered previous value resets to 0.
- Not defined: the inputs are used directly as single-cycle pulses. Holding `stop_in` high in IDLE or ARMED has no effect.

## Structure
- Shared package `tdc_pkg` holds:
  - the state enum `tdc_state_t` (IDLE, ARMED, COUNT, DONE);
  - the default `CNT_WIDTH` constant;
  - the timeout-disable constant `TDC_TIMEOUT_OFF`=0.
- Sub-module `tdc_edge_det` (clk, rst, d → pulse). It is instantiated twice, only under `TDC_EDGE_DETECT_EN`.

## Test plan
- Basic measurement:
  - Stimulus: reset, then `arm`, then start at cycle 10 and stop at cycle 47, with `cfg_timeout`=0 and `result_ready`=1.
  - Response: `result_data`=37, timeout=0, overflow=0, valid for 1 cycle, then IDLE.
- Timeout:
  - Stimulus: `cfg_timeout`=20, start, no stop.
  - Response: `result_data`=20, `result_timeout`=1, valid asserted exactly 20 cycles after the start edge.
- Coincident start and stop:
  - Stimulus: start and stop in the same ARMED cycle.
  - Response: `result_data`=0.
- Stop/timeout tie:
  - Stimulus: `cfg_timeout`=5, stop at k=5.
  - Response: `result_data`=5, `result_timeout`=0.
- Backpressure and abort:
  - Stimulus: `result_ready`=0 for 8 cycles after valid, with `arm` pulsed during DONE.
  - Response: data held stable and `arm` ignored. Releasing `result_ready` returns the FSM to IDLE.
  - Separately, `abort` during COUNT → IDLE next cycle with no `result_valid`.
- Overflow:
  - Stimulus: `CNT_WIDTH`=4, `cfg_timeout`=0, stop at k=30.
  - Response: `result_data`=15, `result_overflow`=1.
  - With `TDC_EDGE_DETECT_EN`, a 6-cycle-wide start level gives the same result as a 1-cycle pulse.
